// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// No logic of its own; pure declarations.
// Imported by the FIFO, the top and the bench.
package pf_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } pfState_e;

  // addi x0,x0,0 - harmless filler word
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pfEntry_t;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Handshake bundle between prefetch buffer, instruction memory and core.
// Wires only, no latency.
// master = prefetch buffer, slave = memory/core environment.
interface inst_prefetch_buffer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_prefetch_buffer_fifo.sv
// DEPTH x {pc,inst} synchronous FIFO with flush.
// Write visible at the head one cycle after push; head read is combinational.
// No internal backpressure: caller never pushes when full or pops when empty.
module pf_fifo
  import pf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     flush,
  input  logic                     push,
  input  pfEntry_t                 pushData,
  input  logic                     pop,
  output pfEntry_t                 headData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  pfEntry_t        store [DEPTH];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;

  assign empty    = (count == '0);
  assign headData = empty ? '0 : store[rdPtr];

  // Pointer and occupancy bookkeeping; flush discards everything including this cycle's push/pop
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents are only observed through the count-gated head
  always_ff @(posedge clk) begin
    if (push && !flush) store[wrPtr] <= pushData;
  end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch: one-outstanding memory fetch into a small FIFO, redirect flushes. Option: PF_BYPASS_EN.
// Latency: grant+response, then one cycle through the FIFO (zero with PF_BYPASS_EN on an empty FIFO).
// Backpressure: inst_ready low fills the FIFO; no new request while the FIFO could not take its response.
module inst_prefetch_buffer
  import pf_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   areset,
  inst_prefetch_buffer_if.master bus
);
  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  pfState_e      state;
  pfState_e      stateNext;
  logic [31:0]   fetchPc;
  logic [31:0]   reqPc;
  logic          drop;
  logic [CW-1:0] count;
  logic          fifoEmpty;
  pfEntry_t      head;
  pfEntry_t      pushData;
  logic          rspOk;
  logic          push;
  logic          pop;
  logic          bypassVld;
  logic          bypassTake;
  logic [31:0]   redirTarget;

  assign redirTarget = {bus.redirect_pc[31:2], 2'b00};
  // A response is kept only if its request was not overtaken by a redirect
  assign rspOk       = (state == WAIT_RSP) && bus.mem_rvalid && !drop && !bus.redirect_valid;

`ifdef PF_BYPASS_EN
  assign bypassVld  = fifoEmpty && (state == WAIT_RSP) && bus.mem_rvalid && !drop;
  assign bypassTake = bypassVld && bus.inst_ready && !bus.redirect_valid;
`else
  assign bypassVld  = 1'b0;
  assign bypassTake = 1'b0;
`endif

  assign push     = rspOk && !bypassTake;
  assign pop      = !fifoEmpty && bus.inst_ready && !bus.redirect_valid;
  assign pushData = '{pc: reqPc, inst: bus.mem_rdata};

  assign bus.inst_valid = !fifoEmpty || bypassVld;
  assign bus.inst_data  = bypassVld ? bus.mem_rdata : head.inst;
  assign bus.inst_pc    = bypassVld ? reqPc         : head.pc;
  assign bus.mem_req    = (state == WAIT_GNT);
  // Address is frozen in reqPc while requesting so a redirect cannot disturb it
  assign bus.mem_addr   = (state == WAIT_GNT) ? reqPc : fetchPc;

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .areset   (areset),
    .flush    (bus.redirect_valid),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .headData (head),
    .empty    (fifoEmpty),
    .count    (count)
  );

  // Fetch FSM state register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state: only issue from IDLE, so at most one transaction is ever outstanding
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (!bus.redirect_valid && (count < DEPTH_C)) stateNext = WAIT_GNT;
      WAIT_GNT: if (bus.mem_gnt)    stateNext = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rvalid) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Fetch address, in-flight request address and stale-response drop flag
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      fetchPc <= RESET_PC;
      reqPc   <= '0;
      drop    <= 1'b0;
    end else begin
      if ((state == IDLE) && (stateNext == WAIT_GNT)) reqPc <= fetchPc;

      // A dropped grant must not advance past the redirect target
      if (bus.redirect_valid)
        fetchPc <= redirTarget;
      else if ((state == WAIT_GNT) && bus.mem_gnt && !drop)
        fetchPc <= fetchPc + PC_INC;

      if ((state == WAIT_GNT) && bus.redirect_valid)
        drop <= 1'b1;
      else if (state == WAIT_RSP) begin
        if (bus.mem_rvalid)          drop <= 1'b0;
        else if (bus.redirect_valid) drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: directed scenarios then random traffic.
// Memory responder with programmable grant/response delays; the core side is
// modelled as an in-order instruction stream restarted at each redirect.
module tb_inst_prefetch_buffer;
  import pf_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  inst_prefetch_buffer_if bus();

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expPc;
  int          consumed;
  int          rspTotal;

  // memory responder knobs and state
  int          gntDelay = 0;
  int          rspDelay = 1;
  logic        pending;
  int          rspWait;
  int          reqCycles;
  logic [31:0] pendAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h0000_00A0 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the core-side stream check happens at the falling edge,
  // then control returns just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (bus.redirect_valid)
      expPc = {bus.redirect_pc[31:2], 2'b00};
    else if (bus.inst_valid && bus.inst_ready) begin
      chk("stream_pc", bus.inst_pc, expPc);
      chk("stream_data", bus.inst_data, memWord(expPc));
      expPc = expPc + 32'd4;
      consumed++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic doRedirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic waitReq(input string tag);
    for (int n = 0; n < 100 && !bus.mem_req; n++) step();
    chk(tag, 32'(bus.mem_req), 32'd1);
  endtask

  task automatic waitConsume(input string tag, input int n);
    int target;
    target = consumed + n;
    for (int k = 0; k < 300 && consumed < target; k++) step();
    chk(tag, 32'(consumed >= target), 32'd1);
  endtask

  // Instruction memory: grant after gntDelay waiting cycles, data rspDelay cycles after grant
  initial begin : memModel
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = NOP;
    pending   = 1'b0;
    rspWait   = 0;
    reqCycles = 0;
    pendAddr  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = NOP;
      if (!areset) begin
        pending   = 1'b0;
        reqCycles = 0;
      end else if (pending) begin
        if (rspWait <= 1) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = memWord(pendAddr);
          pending        = 1'b0;
          rspTotal++;
        end else rspWait--;
      end else if (bus.mem_req) begin
        if (reqCycles >= gntDelay) bus.mem_gnt = 1'b1;
        else reqCycles++;
      end
      @(negedge clk);
      if (areset && bus.mem_gnt && bus.mem_req) begin
        pending   = 1'b1;
        rspWait   = rspDelay;
        pendAddr  = bus.mem_addr;
        reqCycles = 0;
      end
    end
  end

  initial begin : main
    logic [31:0] a;
    logic [31:0] e;
    logic        prev;
    logic        found;
    int          seen;
    int          c0;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    expPc    = 32'h0;
    consumed = 0;
    rspTotal = 0;

    // reset values
    areset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req",   32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc",   bus.inst_pc, 32'h0);
    areset = 1'b1;

    // basic streaming: 0x0..0xC with words 0xA0..0xA3
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 60 && consumed < 4; i++) step();
    chk("t1_count", 32'(consumed), 32'd4);

    // stall: exactly DEPTH words buffered and no further requests
    bus.inst_ready = 1'b0;
    repeat (40) step();
    chk("t2_buffered", 32'(rspTotal - consumed), 32'(DEPTH));
    repeat (4) begin
      chk("t2_no_req", 32'(bus.mem_req), 32'd0);
      chk("t2_valid", 32'(bus.inst_valid), 32'd1);
      step();
    end
    bus.inst_ready = 1'b1;
    waitConsume("t2_drain", 8);

    // reset in the middle of traffic
    repeat (3) step();
    areset = 1'b0;
    step();
    chk("rst2_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst2_mem_req", 32'(bus.mem_req), 32'd0);
    areset   = 1'b1;
    expPc    = 32'h0;
    consumed = 0;
    rspTotal = 0;

    // redirect while the 0x8 response is outstanding
    bus.inst_ready = 1'b0;
    rspDelay = 3;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (pending && pendAddr == 32'h8) found = 1'b1;
      else step();
    end
    chk("t3_reach_rsp8", 32'(found), 32'd1);
    doRedirect(32'h0000_0103);
    chk("t3_flushed", 32'(bus.inst_valid), 32'd0);
    waitReq("t3_req");
    chk("t3_addr", bus.mem_addr, 32'h100);
    bus.inst_ready = 1'b1;
    waitConsume("t3_consume", 2);

    // redirect in the same cycle as a pop and a response
    bus.inst_ready = 1'b0;
    rspDelay = 2;
    seen  = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.mem_rvalid && bus.inst_valid && seen >= 1) found = 1'b1;
      else begin
        if (bus.mem_rvalid) seen++;
        step();
      end
    end
    chk("t4_reach", 32'(found), 32'd1);
    bus.inst_ready = 1'b1;
    doRedirect(32'h0000_0200);
    chk("t4_flushed", 32'(bus.inst_valid), 32'd0);
    waitReq("t4_req");
    chk("t4_addr", bus.mem_addr, 32'h200);
    waitConsume("t4_consume", 2);

    // slow grant: address held for all request cycles, redirect during the wait
    gntDelay = 3;
    rspDelay = 1;
    step();
    prev  = bus.mem_req;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.mem_req && !prev) found = 1'b1;
      else begin
        prev = bus.mem_req;
        step();
      end
    end
    chk("t5_req_rise", 32'(found), 32'd1);
    a = bus.mem_addr;
    chk("t5_req0", 32'(bus.mem_req), 32'd1);
    step();
    chk("t5_req1", 32'(bus.mem_req), 32'd1);
    chk("t5_addr1", bus.mem_addr, a);
    doRedirect(32'h0000_0300);
    chk("t5_req2", 32'(bus.mem_req), 32'd1);
    chk("t5_addr2", bus.mem_addr, a);
    step();
    chk("t5_req3", 32'(bus.mem_req), 32'd1);
    chk("t5_addr3", bus.mem_addr, a);
    chk("t5_gnt3", 32'(bus.mem_gnt), 32'd1);
    step();
    gntDelay = 0;
    waitReq("t5_req_next");
    chk("t5_addr_next", bus.mem_addr, 32'h300);
    waitConsume("t5_consume", 2);

    // response arriving at an empty FIFO with the core ready
    rspDelay = 2;
    repeat (6) step();
    for (int i = 0; i < 50 && !bus.mem_rvalid; i++) step();
    chk("t6_rvalid", 32'(bus.mem_rvalid), 32'd1);
    e = expPc;
`ifdef PF_BYPASS_EN
    chk("t6_byp_valid", 32'(bus.inst_valid), 32'd1);
    chk("t6_byp_pc", bus.inst_pc, e);
    chk("t6_byp_data", bus.inst_data, memWord(e));
    step();
    chk("t6_byp_after", 32'(bus.inst_valid), 32'd0);
`else
    chk("t6_nobyp_valid", 32'(bus.inst_valid), 32'd0);
    step();
    chk("t6_nobyp_next_valid", 32'(bus.inst_valid), 32'd1);
    chk("t6_nobyp_next_pc", bus.inst_pc, e);
`endif
    step();

    // random traffic against the stream model
    c0 = consumed;
    for (int i = 0; i < 600; i++) begin
      gntDelay       = $urandom_range(0, 3);
      rspDelay       = $urandom_range(1, 3);
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) doRedirect($urandom);
      else step();
    end
    chk("rand_progress", 32'((consumed - c0) > 30), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
